// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead byte FIFO and RTS flow control.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo #(
    parameter int CLKFREQ    = 28000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_MARGIN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic       uart_rts,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_read,
    input  logic       clr_err,
    output logic       framing_err,
    output logic       overrun_err,
    output logic       parity_err,
    output logic [2:0] dbg_state
);
    localparam int BITCYC  = CLKFREQ / BAUD;
    localparam int HALFCYC = BITCYC / 2;
    localparam int CW      = $clog2(BITCYC) + 1;
    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    // Counter expires at zero, so loads are one short of the wanted interval.
    localparam logic [CW-1:0]         HALF_LD  = CW'(HALFCYC - 1);
    localparam logic [CW-1:0]         BIT_LD   = CW'(BITCYC - 1);
    localparam logic [CW-1:0]         CNT_DEC  = CW'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   RTS_LVL  = (DEPTH_LOG2+1)'(DEPTH - RTS_MARGIN);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic                  rx_meta_q, rxs_q;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_bad_q, par_bad_d;
    logic                  expire;
    logic                  push_req, frame_ev, parity_ev;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push, pop, full, overrun_ev;
    logic                  rts_q, fe_q, oe_q, pe_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    assign expire = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = expire ? cnt_q : cnt_q - CNT_DEC;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        case (state_q)
            S_IDLE: if (!rxs_q) begin
                state_d = S_START;
                cnt_d   = HALF_LD;
            end
            S_START: if (expire) begin
                if (!rxs_q) begin
                    state_d   = S_DATA;
                    cnt_d     = BIT_LD;
                    bit_idx_d = '0;
                    par_bad_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: if (expire) begin
                shift_d   = {rxs_q, shift_q[7:1]};
                cnt_d     = BIT_LD;
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (expire) begin
                par_bad_d = ^{rxs_q, shift_q};
                cnt_d     = BIT_LD;
                state_d   = S_STOP;
            end
`endif
            S_STOP: if (expire) state_d = rxs_q ? S_IDLE : S_BREAK;
            S_BREAK: if (rxs_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A byte with bad parity is still stop-checked but never pushed.
    always_comb begin
        push_req = (state_q == S_STOP) && expire && rxs_q && !par_bad_q;
        frame_ev = (state_q == S_STOP) && expire && !rxs_q;
`ifdef UART_RX_PARITY_EN
        parity_ev = (state_q == S_PARITY) && expire && (^{rxs_q, shift_q});
`else
        parity_ev = 1'b0;
`endif
    end

    assign dbg_state = state_q;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign full       = (count_q == CNT_FULL);
    assign pop        = rx_read && (count_q != '0);
    assign push       = push_req && (!full || pop);
    assign overrun_ev = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rts_q    <= 1'b1;
            fe_q     <= 1'b0;
            oe_q     <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            rts_q   <= (count_q >= RTS_LVL);
            fe_q    <= (fe_q & ~clr_err) | frame_ev;
            oe_q    <= (oe_q & ~clr_err) | overrun_ev;
            pe_q    <= (pe_q & ~clr_err) | parity_ev;
        end
    end

    assign rx_data     = mem_q[rd_ptr_q];
    assign rx_valid    = (count_q != '0);
    assign uart_rts    = rts_q;
    assign framing_err = fe_q;
    assign overrun_err = oe_q;
    assign parity_err  = pe_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (243 clocks per bit).
module tb_uart_rx_fifo;
    localparam int BITCYC  = 243;
    localparam int HALFCYC = 121;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Negedges from driving the start bit to the negedge just before the stop sample edge.
    localparam int STOP_SAMPLE = 2 + HALFCYC + (NBITS - 1) * BITCYC;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_read = 1'b0;
    logic       clr_err = 1'b0;
    logic       uart_rts;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err, overrun_err, parity_err;
    logic [2:0] dbg_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    uart_rx_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_rx    (uart_rx),
        .uart_rts   (uart_rts),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_read    (rx_read),
        .clr_err    (clr_err),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .parity_err (parity_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] make_frame(input logic [7:0] b);
        logic [15:0] f;
        f      = 16'hFFFF;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_RX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic send_raw(input logic [15:0] f, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            uart_rx = f[i];
            repeat (BITCYC) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_raw(make_frame(b), NBITS);
    endtask

    task automatic pulse_read();
        @(negedge clk) rx_read = 1'b1;
        @(negedge clk) rx_read = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (uart_rts !== 1'b1) $display("FAIL rst_rts: got %0b exp 1", uart_rts); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL rst_valid: got %0b exp 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'h00) $display("FAIL rst_data: got %h exp 00", rx_data); else pass_cnt++;
        chk_cnt++; if ({framing_err, overrun_err, parity_err} !== 3'b000)
            $display("FAIL rst_errs: got %b exp 000", {framing_err, overrun_err, parity_err}); else pass_cnt++;
        chk_cnt++; if (dbg_state !== 3'd0) $display("FAIL rst_state: got %0d exp 0", dbg_state); else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if (uart_rts !== 1'b0) $display("FAIL rst_rts_fall: got %0b exp 0", uart_rts); else pass_cnt++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic();
        fork
            send_frame(8'hA5);
            begin
                @(negedge clk);
                repeat (STOP_SAMPLE) @(negedge clk);
                chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL basic_valid_early: got %0b exp 0", rx_valid); else pass_cnt++;
                @(negedge clk);
                chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL basic_valid_rise: got %0b exp 1", rx_valid); else pass_cnt++;
            end
        join
        chk_cnt++; if (rx_data !== 8'hA5) $display("FAIL basic_data: got %h exp a5", rx_data); else pass_cnt++;
        chk_cnt++; if ({framing_err, overrun_err, parity_err} !== 3'b000)
            $display("FAIL basic_errs: got %b exp 000", {framing_err, overrun_err, parity_err}); else pass_cnt++;
        pulse_read();
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL basic_pop: got %0b exp 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_glitch();
        @(negedge clk) uart_rx = 1'b0;
        repeat (60) @(negedge clk);
        uart_rx = 1'b1;
        repeat (300) @(negedge clk);
        chk_cnt++; if (dbg_state !== 3'd0) $display("FAIL glitch_state: got %0d exp 0", dbg_state); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL glitch_valid: got %0b exp 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (framing_err !== 1'b0) $display("FAIL glitch_ferr: got %0b exp 0", framing_err); else pass_cnt++;
    endtask

    task automatic test_framing();
        logic [15:0] f;
        f = make_frame(8'h3C);
        f[NBITS-1] = 1'b0;
        f[NBITS]   = 1'b0;
        send_raw(f, NBITS + 1);
        repeat (20) @(negedge clk);
        chk_cnt++; if (framing_err !== 1'b1) $display("FAIL frm_ferr: got %0b exp 1", framing_err); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL frm_valid: got %0b exp 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (dbg_state !== 3'd0) $display("FAIL frm_state: got %0d exp 0", dbg_state); else pass_cnt++;
        send_frame(8'h11);
        chk_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h11)
            $display("FAIL frm_next: got v=%0b d=%h exp v=1 d=11", rx_valid, rx_data); else pass_cnt++;
        chk_cnt++; if (framing_err !== 1'b1) $display("FAIL frm_sticky: got %0b exp 1", framing_err); else pass_cnt++;
        pulse_read();
        pulse_clr();
        chk_cnt++; if (framing_err !== 1'b0) $display("FAIL frm_clr: got %0b exp 0", framing_err); else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 12; i++) begin
            send_frame(8'(i));
            if (i == 10) begin
                chk_cnt++; if (uart_rts !== 1'b0) $display("FAIL fill_rts_11: got %0b exp 0", uart_rts); else pass_cnt++;
            end
        end
        chk_cnt++; if (uart_rts !== 1'b1) $display("FAIL fill_rts_12: got %0b exp 1", uart_rts); else pass_cnt++;
        for (int i = 12; i < 16; i++) send_frame(8'(i));
        chk_cnt++; if (overrun_err !== 1'b0) $display("FAIL fill_no_ovr: got %0b exp 0", overrun_err); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'h00) $display("FAIL fill_head: got %h exp 00", rx_data); else pass_cnt++;
        send_frame(8'h10);
        chk_cnt++; if (overrun_err !== 1'b1) $display("FAIL fill_ovr: got %0b exp 1", overrun_err); else pass_cnt++;
        pulse_clr();
        chk_cnt++; if (overrun_err !== 1'b0) $display("FAIL fill_ovr_clr: got %0b exp 0", overrun_err); else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        fork
            send_frame(8'h20);
            begin
                @(negedge clk);
                repeat (STOP_SAMPLE) @(negedge clk);
                chk_cnt++; if (rx_data !== 8'h00) $display("FAIL pp_head: got %h exp 00", rx_data); else pass_cnt++;
                rx_read = 1'b1;
                @(negedge clk) rx_read = 1'b0;
            end
        join
        chk_cnt++; if (overrun_err !== 1'b0) $display("FAIL pp_no_ovr: got %0b exp 0", overrun_err); else pass_cnt++;
        chk_cnt++; if (uart_rts !== 1'b1) $display("FAIL pp_rts: got %0b exp 1", uart_rts); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 15) ? 8'(i + 1) : 8'h20;
            @(negedge clk);
            chk_cnt++; if (rx_valid !== 1'b1 || rx_data !== exp_b)
                $display("FAIL drain_%0d: got v=%0b d=%h exp v=1 d=%h", i, rx_valid, rx_data, exp_b); else pass_cnt++;
            pulse_read();
        end
        @(negedge clk);
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL drain_empty: got %0b exp 0", rx_valid); else pass_cnt++;
        chk_cnt++; if (uart_rts !== 1'b0) $display("FAIL drain_rts: got %0b exp 0", uart_rts); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h55);
        @(negedge clk) uart_rx = 1'b0;
        repeat (5 * BITCYC) @(negedge clk);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++; if (uart_rts !== 1'b1) $display("FAIL mid_rts: got %0b exp 1", uart_rts); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0 || rx_data !== 8'h00)
            $display("FAIL mid_fifo: got v=%0b d=%h exp v=0 d=00", rx_valid, rx_data); else pass_cnt++;
        chk_cnt++; if (dbg_state !== 3'd0) $display("FAIL mid_state: got %0d exp 0", dbg_state); else pass_cnt++;
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        send_frame(8'h7E);
        chk_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h7E)
            $display("FAIL mid_next: got v=%0b d=%h exp v=1 d=7e", rx_valid, rx_data); else pass_cnt++;
        chk_cnt++; if ({framing_err, overrun_err, parity_err} !== 3'b000)
            $display("FAIL mid_errs: got %b exp 000", {framing_err, overrun_err, parity_err}); else pass_cnt++;
        pulse_read();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [15:0] f;
        f = make_frame(8'h01);
        f[9] = 1'b0;
        send_raw(f, NBITS);
        repeat (5) @(negedge clk);
        chk_cnt++; if (parity_err !== 1'b1) $display("FAIL par_err: got %0b exp 1", parity_err); else pass_cnt++;
        chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL par_drop: got %0b exp 0", rx_valid); else pass_cnt++;
        pulse_clr();
        send_frame(8'h01);
        chk_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h01)
            $display("FAIL par_good: got v=%0b d=%h exp v=1 d=01", rx_valid, rx_data); else pass_cnt++;
        chk_cnt++; if (parity_err !== 1'b0) $display("FAIL par_clean: got %0b exp 0", parity_err); else pass_cnt++;
        pulse_read();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_fill();
        test_full_push_pop();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
